decode_stage: RTL and testbench

Registered RV32I/RV64I instruction-decode pipeline stage sitting between the fetch stage and the execute stage of the core. It accepts one instruction per cycle over a valid/ready handshake and reads the register file combinationally. It holds the decoded fields, sign-extended immediates, operands and control bundle in an ID/EX output register. It adds a load-use interlock, flush and a halt-drain state machine to the combinational decoder generation.

---
 rtl/decode_pkg.sv | 33 +++
 rtl/imm_gen.sv | 34 +++
 rtl/decode_stage.sv | 152 +++++++++++++++
 tb/tb_decode_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants: RV32I/RV64I opcodes, control-bundle bit positions
// and the halt-drain state encoding.
package decode_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam int CTRL_W      = 10;
    localparam int CTRL_LUI    = 9;
    localparam int CTRL_AUIPC  = 8;
    localparam int CTRL_OPIMM  = 7;
    localparam int CTRL_OP     = 6;
    localparam int CTRL_JAL    = 5;
    localparam int CTRL_JALR   = 4;
    localparam int CTRL_BRANCH = 3;
    localparam int CTRL_LOAD   = 2;
    localparam int CTRL_STORE  = 1;
    localparam int CTRL_RF_WE  = 0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: builds every RV32I immediate format and
// sign-extends it from inst[31] to XLEN.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     in_inst,
    output logic [XLEN-1:0] immI,
    output logic [XLEN-1:0] immS,
    output logic [XLEN-1:0] immB,
    output logic [XLEN-1:0] immU,
    output logic [XLEN-1:0] immJ
);

    logic signed [31:0] i32, s32, b32, u32, j32;
    logic               unused_opcode;

    always_comb begin
        i32 = {{20{in_inst[31]}}, in_inst[31:20]};
        s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        u32 = {in_inst[31:12], 12'b0};
        j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    end

    // Widening a signed 32-bit value replicates bit 31 up to XLEN.
    assign immI = XLEN'(i32);
    assign immS = XLEN'(s32);
    assign immB = XLEN'(b32);
    assign immU = XLEN'(u32);
    assign immJ = XLEN'(j32);

    assign unused_opcode = ^in_inst[6:0];

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes, reads operands, interlocks on
// load-use hazards and drains to a sticky halt on the halt instruction.
module decode_stage
    import decode_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] HALT_INST   = 32'h00008067,
    parameter logic [31:0] HALT_RA_VAL = 32'h0000000c
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic [4:0]        RF_RA1,
    output logic [4:0]        RF_RA2,
    input  logic [XLEN-1:0]   RF_RD1,
    input  logic [XLEN-1:0]   RF_RD2,
    input  logic              ex_load_pending,
    input  logic [4:0]        ex_load_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [6:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_oprnd2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal,
    output logic              HALT
);

    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [XLEN-1:0]   immI, immS, immB, immU, immJ;
    logic [XLEN-1:0]   imm_d, oprnd2_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              illegal_d, use_rs1, use_rs2, writes_rd;
    logic              hazard, accept, halt_hit;
    state_e            state_q, state_d;
    logic              valid_q, valid_d;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[11:7];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign RF_RA1 = rs1;
    assign RF_RA2 = rs2;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .in_inst (in_inst),
        .immI    (immI),
        .immS    (immS),
        .immB    (immB),
        .immU    (immU),
        .immJ    (immJ)
    );

    always_comb begin
        ctrl_d    = '0;
        imm_d     = '0;
        oprnd2_d  = '0;
        illegal_d = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            LUI:    begin ctrl_d[CTRL_LUI]    = 1'b1; imm_d = immU; oprnd2_d = immU; writes_rd = 1'b1; end
            AUIPC:  begin ctrl_d[CTRL_AUIPC]  = 1'b1; imm_d = immU; oprnd2_d = immU; writes_rd = 1'b1; end
            OP_IMM: begin ctrl_d[CTRL_OPIMM]  = 1'b1; imm_d = immI; oprnd2_d = immI; writes_rd = 1'b1; use_rs1 = 1'b1; end
            OP:     begin ctrl_d[CTRL_OP]     = 1'b1; oprnd2_d = RF_RD2; writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            JAL:    begin ctrl_d[CTRL_JAL]    = 1'b1; imm_d = immJ; oprnd2_d = immJ; writes_rd = 1'b1; end
            JALR:   begin ctrl_d[CTRL_JALR]   = 1'b1; imm_d = immI; oprnd2_d = immI; writes_rd = 1'b1; use_rs1 = 1'b1; end
            BRANCH: begin ctrl_d[CTRL_BRANCH] = 1'b1; imm_d = immB; oprnd2_d = RF_RD2; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            LOAD:   begin ctrl_d[CTRL_LOAD]   = 1'b1; imm_d = immI; oprnd2_d = immI; writes_rd = 1'b1; use_rs1 = 1'b1; end
            STORE:  begin ctrl_d[CTRL_STORE]  = 1'b1; imm_d = immS; oprnd2_d = immS; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default: illegal_d = 1'b1;
        endcase
        ctrl_d[CTRL_RF_WE] = writes_rd && (rd != 5'd0);
    end

    // Stall only when the load in execute writes a register this instruction reads.
    assign hazard = in_valid && ex_load_pending && (ex_load_rd != 5'd0)
                 && ((use_rs1 && (rs1 == ex_load_rd)) || (use_rs2 && (rs2 == ex_load_rd)));
    assign in_ready = (state_q == RUN) && !hazard && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign halt_hit = (in_inst == HALT_INST) && (RF_RD1 == XLEN'(HALT_RA_VAL));

    always_comb begin
        state_d = state_q;
        if (flush && (state_q != HALTED)) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (accept && halt_hit) state_d = DRAIN;
                DRAIN:   if (valid_q && out_ready) state_d = HALTED;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= RUN;
            valid_q     <= 1'b0;
            out_pc      <= '0;
            out_opcode  <= '0;
            out_rd      <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_imm     <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_oprnd2  <= '0;
            out_ctrl    <= '0;
            out_illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (accept) begin
                out_pc      <= in_pc;
                out_opcode  <= opcode;
                out_rd      <= rd;
                out_funct3  <= in_inst[14:12];
                out_funct7  <= in_inst[31:25];
                out_imm     <= imm_d;
                out_rs1_val <= RF_RD1;
                out_rs2_val <= RF_RD2;
                out_oprnd2  <= oprnd2_d;
                out_ctrl    <= ctrl_d;
                out_illegal <= illegal_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign HALT      = (state_q == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, load-use stall, backpressure,
// halt drain/flush and a 64-bit immediate sign-extension check.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal, HALT;
    logic [31:0] in_inst, in_pc, RF_RD1, RF_RD2;
    logic [4:0]  RF_RA1, RF_RA2, ex_load_rd, out_rd;
    logic        ex_load_pending;
    logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val, out_oprnd2;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [9:0]  out_ctrl;

    logic        in_valid_w, in_ready_w, out_valid_w, out_illegal_w, halt_w;
    logic [31:0] in_inst_w;
    logic [63:0] in_pc_w, rd1_w, rd2_w;
    logic [4:0]  ra1_w, ra2_w, out_rd_w;
    logic [63:0] out_pc_w, out_imm_w, out_rs1_w, out_rs2_w, out_oprnd2_w;
    logic [6:0]  out_opcode_w, out_funct7_w;
    logic [2:0]  out_funct3_w;
    logic [9:0]  out_ctrl_w;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    decode_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .RF_RA1(RF_RA1), .RF_RA2(RF_RA2),
        .RF_RD1(RF_RD1), .RF_RD2(RF_RD2), .ex_load_pending(ex_load_pending),
        .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_oprnd2(out_oprnd2), .out_ctrl(out_ctrl), .out_illegal(out_illegal),
        .HALT(HALT)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_inst(in_inst_w), .in_pc(in_pc_w), .RF_RA1(ra1_w), .RF_RA2(ra2_w),
        .RF_RD1(rd1_w), .RF_RD2(rd2_w), .ex_load_pending(1'b0),
        .ex_load_rd(5'd0), .flush(1'b0), .out_valid(out_valid_w),
        .out_ready(1'b1), .out_pc(out_pc_w), .out_opcode(out_opcode_w),
        .out_rd(out_rd_w), .out_funct3(out_funct3_w), .out_funct7(out_funct7_w),
        .out_imm(out_imm_w), .out_rs1_val(out_rs1_w), .out_rs2_val(out_rs2_w),
        .out_oprnd2(out_oprnd2_w), .out_ctrl(out_ctrl_w), .out_illegal(out_illegal_w),
        .HALT(halt_w)
    );

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", out_valid); end
        total++; if (out_ctrl !== 10'h000) begin bad++; $display("FAIL rst_ctrl got=%h exp=000", out_ctrl); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
        total++; if (HALT !== 1'b0) begin bad++; $display("FAIL rst_halt got=%h exp=0", HALT); end
        RSTn = 1'b1;
        step();
    endtask

    task automatic test_addi();
        RF_RD1 = 32'h0; RF_RD2 = 32'h55; out_ready = 1'b1;
        present(32'hfff00293, 32'h100);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%h exp=1", in_ready); end
        total++; if (RF_RA2 !== 5'd31) begin bad++; $display("FAIL addi_ra2 got=%h exp=1f", RF_RA2); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%h exp=1", out_valid); end
        total++; if (out_imm !== 32'hffffffff) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffff", out_imm); end
        total++; if (out_oprnd2 !== 32'hffffffff) begin bad++; $display("FAIL addi_op2 got=%h exp=ffffffff", out_oprnd2); end
        total++; if (out_ctrl !== 10'h081) begin bad++; $display("FAIL addi_ctrl got=%h exp=081", out_ctrl); end
        total++; if (out_rd !== 5'd5 || out_pc !== 32'h100) begin bad++; $display("FAIL addi_rd_pc got=%h/%h exp=5/100", out_rd, out_pc); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drop got=%h exp=0", out_valid); end
    endtask

    task automatic test_load_use();
        ex_load_pending = 1'b1; ex_load_rd = 5'd6; RF_RD1 = 32'h11; RF_RD2 = 32'h22;
        present(32'h002303b3, 32'h104);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%h exp=0", in_ready); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%h exp=0", out_valid); end
        ex_load_pending = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_release got=%h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin bad++; $display("FAIL lu_accept got=%h/%h exp=1/7", out_valid, out_rd); end
        total++; if (out_ctrl !== 10'h041 || out_oprnd2 !== 32'h22) begin bad++; $display("FAIL lu_ctrl got=%h/%h exp=041/22", out_ctrl, out_oprnd2); end
        step();
    endtask

    task automatic test_no_stall();
        ex_load_pending = 1'b1; ex_load_rd = 5'd6;
        present(32'h000003b3, 32'h108);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ns_ready got=%h exp=1", in_ready); end
        step();
        total++; if (out_ctrl !== 10'h041) begin bad++; $display("FAIL ns_ctrl got=%h exp=041", out_ctrl); end
        present(32'h00000013, 32'h10c);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_ctrl !== 10'h080 || out_pc !== 32'h10c) begin bad++; $display("FAIL x0_nowe got=%h/%h exp=080/10c", out_ctrl, out_pc); end
        ex_load_pending = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        present(32'h800000b7, 32'h200);
        step();
        present(32'h0020a423, 32'h204);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%h exp=0", k, in_ready); end
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_imm !== 32'h80000000 || out_ctrl !== 10'h201)
                begin bad++; $display("FAIL bp_hold%0d got=%h/%h/%h/%h exp=1/200/80000000/201", k, out_valid, out_pc, out_imm, out_ctrl); end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_pc !== 32'h204 || out_imm !== 32'h8 || out_oprnd2 !== 32'h8 || out_ctrl !== 10'h002)
            begin bad++; $display("FAIL bp_next got=%h/%h/%h/%h exp=204/8/8/002", out_pc, out_imm, out_oprnd2, out_ctrl); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%h exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        present(32'h0000007f, 32'h300);
        step();
        in_valid = 1'b0;
        total++; if (out_illegal !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL ill_flag got=%h/%h exp=1/1", out_illegal, out_valid); end
        total++; if (out_ctrl !== 10'h000 || out_imm !== 32'h0) begin bad++; $display("FAIL ill_ctrl got=%h/%h exp=000/0", out_ctrl, out_imm); end
        step();
    endtask

    task automatic test_halt();
        RF_RD1 = 32'h0;
        present(32'h00008067, 32'h400);
        step();
        present(32'h00000013, 32'h404);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL halt_unqual got=%h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        step();
        RF_RD1 = 32'hc; out_ready = 1'b0;
        present(32'h00008067, 32'h408);
        step();
        present(32'h00000013, 32'h40c);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0 || HALT !== 1'b0) begin bad++; $display("FAIL drain_ready got=%h/%h exp=0/0", in_ready, HALT); end
        step();
        total++; if (HALT !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL halted got=%h/%h exp=1/0", HALT, out_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        total++; if (HALT !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL halt_sticky got=%h/%h exp=1/0", HALT, in_ready); end
        in_valid = 1'b0;
        RSTn = 1'b0;
        #1;
        total++; if (HALT !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL halt_reset got=%h/%h exp=0/0", HALT, out_valid); end
        @(negedge CLK);
        RSTn = 1'b1;
        step();
    endtask

    task automatic test_halt_flush();
        RF_RD1 = 32'hc; out_ready = 1'b0;
        present(32'h00008067, 32'h500);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%h exp=0", in_ready); end
        step();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || HALT !== 1'b0) begin bad++; $display("FAIL flush_drop got=%h/%h exp=0/0", out_valid, HALT); end
        RF_RD1 = 32'h0; out_ready = 1'b1;
        present(32'h00000013, 32'h504);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_run got=%h exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        step();
        total++; if (HALT !== 1'b0) begin bad++; $display("FAIL flush_nohalt got=%h exp=0", HALT); end
    endtask

    task automatic test_xlen64();
        in_inst_w = 32'hfe000ee3; in_pc_w = 64'h1000; rd1_w = 64'h0; rd2_w = 64'h0123456789abcdef;
        in_valid_w = 1'b1;
        step();
        in_valid_w = 1'b0;
        total++; if (out_imm_w !== 64'hfffffffffffffffc) begin bad++; $display("FAIL x64_immb got=%h exp=fffffffffffffffc", out_imm_w); end
        total++; if (out_ctrl_w !== 10'h008 || out_oprnd2_w !== 64'h0123456789abcdef)
            begin bad++; $display("FAIL x64_branch got=%h/%h exp=008/0123456789abcdef", out_ctrl_w, out_oprnd2_w); end
        step();
    endtask

    initial begin
        RSTn = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;
        RF_RD1 = 32'h0; RF_RD2 = 32'h0; ex_load_pending = 1'b0; ex_load_rd = 5'd0;
        flush = 1'b0; out_ready = 1'b1;
        in_valid_w = 1'b0; in_inst_w = 32'h0; in_pc_w = 64'h0; rd1_w = 64'h0; rd2_w = 64'h0;
        test_reset();
        test_addi();
        test_load_use();
        test_no_stall();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_halt_flush();
        test_xlen64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
